// File: rtl/cal_sequencer_pkg.sv
// Shared types and constants for the four-corner calibration sequencer.
package cal_sequencer_pkg;

  localparam logic [9:0] NO_BLOB = 10'd1023;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLOB,
    ACCUM,
    WAIT_RELEASE,
    DONE
  } state_t;

  typedef logic [1:0] corner_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } sample_t;

  function automatic logic [3:0] corner_onehot(corner_t k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/cal_sequencer_if.sv
// Camera sample stream in, LED indicator and corner table out.
interface cal_sequencer_if;
  logic        start;
  logic        sample_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [3:0]  led;
  logic        busy;
  logic        done;
  logic [39:0] corner_x;
  logic [39:0] corner_y;

  modport master (
    output start, sample_valid, x, y,
    input  led, busy, done, corner_x, corner_y
  );

  modport slave (
    input  start, sample_valid, x, y,
    output led, busy, done, corner_x, corner_y
  );
endinterface

// File: rtl/cal_sequencer_accum.sv
// Per-corner stability tracker: anchor, tolerance window, running sums and average.
module corner_accum
  import cal_sequencer_pkg::*;
#(
  parameter int LOG2_SAMPLES = 4,
  parameter int TOL          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  add,
  input  logic                  clear,
  input  sample_t               smp,
  output logic                  in_tol,
  output logic [LOG2_SAMPLES:0] cnt,
  output logic [9:0]            avg_x,
  output logic [9:0]            avg_y
);
  localparam int SW = 10 + LOG2_SAMPLES;

  sample_t       anchor;
  logic [SW-1:0] sum_x, sum_y, nxt_x, nxt_y;
  logic [9:0]    dx, dy;

  always_comb begin
    dx     = (smp.x >= anchor.x) ? smp.x - anchor.x : anchor.x - smp.x;
    dy     = (smp.y >= anchor.y) ? smp.y - anchor.y : anchor.y - smp.y;
    in_tol = (dx <= 10'(TOL)) && (dy <= 10'(TOL));
    // Average includes the current sample so the capture lands on the Nth strobe.
    nxt_x  = sum_x + SW'(smp.x);
    nxt_y  = sum_y + SW'(smp.y);
    avg_x  = nxt_x[SW-1:LOG2_SAMPLES];
    avg_y  = nxt_y[SW-1:LOG2_SAMPLES];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      anchor <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      cnt    <= '0;
    end else if (clear) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (load) begin
      anchor <= smp;
      sum_x  <= SW'(smp.x);
      sum_y  <= SW'(smp.y);
      cnt    <= (LOG2_SAMPLES+1)'(1);
    end else if (add) begin
      sum_x <= nxt_x;
      sum_y <= nxt_y;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cal_sequencer.sv
// Calibration FSM: walks the four corners, captures stable averages into the corner table.
module cal_sequencer
  import cal_sequencer_pkg::*;
#(
  parameter int LOG2_SAMPLES = 4,
  parameter int TOL          = 8
) (
  input  logic           clk,
  input  logic           reset,
  cal_sequencer_if.slave bus
);
  localparam int N = 1 << LOG2_SAMPLES;

  state_t                state;
  corner_t               k;
  logic [3:0][9:0]       tab_x, tab_y;
  logic [3:0]            led_q;
  logic                  busy_q, done_q;
  logic                  present, load, add, clear, in_tol;
  logic [LOG2_SAMPLES:0] cnt;
  logic [9:0]            avg_x, avg_y;
  sample_t               smp;

  assign smp          = '{x: bus.x, y: bus.y};
  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.corner_x = tab_x;
  assign bus.corner_y = tab_y;

  always_comb begin
    present = bus.sample_valid && (bus.y != NO_BLOB);
    load    = (state == WAIT_BLOB) && present;
    add     = (state == ACCUM) && present && in_tol;
    clear   = (state == ACCUM) && bus.sample_valid && !(present && in_tol);
  end

  corner_accum #(.LOG2_SAMPLES(LOG2_SAMPLES), .TOL(TOL)) u_accum (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .add   (add),
    .clear (clear),
    .smp   (smp),
    .in_tol(in_tol),
    .cnt   (cnt),
    .avg_x (avg_x),
    .avg_y (avg_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      tab_x  <= '0;
      tab_y  <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          k      <= '0;
          state  <= WAIT_BLOB;
          led_q  <= 4'b0001;
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end
        WAIT_BLOB: if (present) state <= ACCUM;
        ACCUM: begin
          if (clear) state <= WAIT_BLOB;
          else if (add && cnt == (LOG2_SAMPLES+1)'(N-1)) begin
            tab_x[k] <= avg_x;
            tab_y[k] <= avg_y;
            state    <= WAIT_RELEASE;
          end
        end
        // Only a no-blob strobe releases, so a held blob cannot spill into the next corner.
        WAIT_RELEASE: if (bus.sample_valid && bus.y == NO_BLOB) begin
          if (k == 2'd3) begin
            state  <= DONE;
            led_q  <= 4'b1111;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            k     <= k + 2'd1;
            led_q <= corner_onehot(k + 2'd1);
            state <= WAIT_BLOB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cal_sequencer.md
# cal_sequencer

Four-corner calibration controller for the blob-tracking path. On request it steps the user through the four projection corners, using the four indicator LEDs to show the target corner. At each corner it accepts a blob only once it has stayed still for a fixed number of camera frames, then stores the averaged (x, y). It sits between the camera sample stream and the LED pins, and its corner table feeds the coordinate-mapping logic downstream.

## Interface
- LOG2_SAMPLES, 4: log2 of the number of stable frames averaged per corner (N = 16).
- TOL, 8: maximum |dx| and |dy| (pixels) from the anchor sample that still counts as stable.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin calibration; sampled only in IDLE or DONE.
- sample_valid  in  1  one-cycle strobe per camera frame; x and y are valid in this cycle.
- x  in  10  blob x coordinate.
- y  in  10  blob y coordinate; 1023 means no blob.
- led  out  4  target indicator, one-hot on the current corner index (bit k = corner k).
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  high while in DONE.
- corner_x  out  40  packed averaged x, corner k at bits [10k+9:10k].
- corner_y  out  40  packed averaged y, same packing.

## Operation
- States: IDLE, WAIT_BLOB, ACCUM, WAIT_RELEASE, DONE.
- A sample is "present" when sample_valid=1 and y != 1023. Cycles with sample_valid=0 never change state or counters.
- IDLE or DONE, start=1: clear k to 0, go to WAIT_BLOB. corner_x/corner_y keep their old contents until overwritten.
- WAIT_BLOB, present sample:
  - Load anchor = (x, y), sum_x = x, sum_y = y, cnt = 1.
  - Go to ACCUM.
- ACCUM, sample_valid with no blob, or |x - anchor_x| > TOL, or |y - anchor_y| > TOL: discard the sums, set cnt = 0, go to WAIT_BLOB. The rejecting sample does not become a new anchor.
- ACCUM, in-tolerance present sample:
  - Add x and y to the sums and increment cnt.
  - If this is sample N, write (sum + x) >> LOG2_SAMPLES (and the y equivalent, truncating) into slot k, then go to WAIT_RELEASE.
- WAIT_RELEASE, sample with y == 1023:
  - If k == 3, go to DONE.
  - Otherwise increment k and go to WAIT_BLOB.
  - Present samples are ignored here, so one long hold cannot calibrate two corners.
- Arithmetic:
  - Sums are 10+LOG2_SAMPLES bits unsigned, so there is no overflow.
  - Distances are computed as unsigned differences, larger minus smaller.
  - Tolerance compare is inclusive (|d| == TOL passes).
- led:
  - one-hot(k) in WAIT_BLOB, ACCUM and WAIT_RELEASE.
  - 4'b1111 in DONE.
  - 4'b0000 in IDLE.
- start in WAIT_BLOB, ACCUM or WAIT_RELEASE is ignored. Calibration is never restarted mid-run except by reset.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, k 0, cnt 0.
  - led 0, busy 0, done 0.
  - corner_x and corner_y all zero.
- start accepted at edge t: at t+1 state is WAIT_BLOB, busy=1 and led=0001.
- The Nth stable sample at edge t updates its corner slot and moves to WAIT_RELEASE at t+1.
- Release of corner 3 at edge t: at t+1, done=1, busy=0 and led=1111.
- Minimum run length: 4×(N+1) sample strobes (N to capture each corner plus one no-blob strobe to release it).
- Reset asserted mid-run returns to IDLE on the next edge and clears the corner table.

## Structure
- Shared package contents:
  - NO_BLOB = 10'd1023.
  - State encoding.
  - Corner index type (2 bits).
- One sub-module, corner_accum: holds the anchor, the tolerance check, the sums, the count and the averaged result. It is driven by load, add and clear strobes from the FSM.
- The FSM and corner table live in cal_sequencer.

## Test plan
- Nominal run:
  - Stimulus: start, then 16 present samples at (100,80), one no-blob strobe; repeat at (900,80), (100,700), (900,700).
  - Required: corner_x = {900,100,900,100} and corner_y = {700,700,80,80} in slots 3..0, done=1, led sequence 0001→0010→0100→1000→1111.
- Jitter within tolerance:
  - Stimulus: at corner 0, alternate x=100/108 for 16 samples with y fixed at 80.
  - Required: slot 0 x = 104, capture after exactly 16 samples.
- Tolerance break:
  - Stimulus: 10 samples at (100,80), then 1 at (109,80), then 16 at (200,80).
  - Required: slot 0 = (200,80) and no capture before the 27th strobe.
- Blob lost:
  - Stimulus: 8 samples, one y=1023 strobe, 16 samples.
  - Required: capture only after the final 16.
  - Additionally, strobe-less gaps between samples must not reset cnt.
- Release and restart rules:
  - Stimulus: hold the blob 40 strobes after capture.
  - Required: k stays 0 (WAIT_RELEASE).
  - Stimulus: start asserted mid-run.
  - Required: ignored.
- Reset mid-ACCUM:
  - Stimulus: assert reset during ACCUM.
  - Required: next cycle IDLE, led=0, all corners 0.
  - Stimulus: start from DONE.
  - Required: restarts at corner 0.
